shift_pipe: RTL and testbench

Parametrised, pipelined shift unit for the execute stage: replaces the single-function 32-bit combinational arithmetic right shift with a WIDTH-bit logarithmic shifter supporting SLL, SRL, SRA, ROL and ROR. The mux levels are split across STAGES registered pipeline stages, with valid/ready handshakes and a flush for branch squash. A TAG field travels alongside each operation, typically the destination register index, so writeback stays aligned with its data.

---
 rtl/shift_pkg.sv | 30 +++
 rtl/shift_level.sv | 34 +++
 rtl/shift_pipe.sv | 117 +++++++++++
 tb/tb_shift_pipe.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined shift unit.
package shift_pkg;

  typedef enum logic [2:0] {
    SHIFT_SLL = 3'd0,
    SHIFT_SRL = 3'd1,
    SHIFT_SRA = 3'd2,
    SHIFT_ROL = 3'd3,
    SHIFT_ROR = 3'd4
  } shift_op_e;

  function automatic int shamt_width(input int width);
    return $clog2(width);
  endfunction

  // Pipeline stage that owns mux level k.
  function automatic int stage_of(input int k, input int stages, input int shw);
    return (k * stages) / shw;
  endfunction

  function automatic logic is_right(input logic [2:0] op);
    return (op == SHIFT_SRL) || (op == SHIFT_SRA) || (op == SHIFT_ROR);
  endfunction

  // Codes 5..7 are reserved and pass the operand through untouched.
  function automatic logic is_legal(input logic [2:0] op);
    return op <= SHIFT_ROR;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One logarithmic shifter level: conditional shift/rotate by 2^K.
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [2:0]       op,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int SH = 1 << K;

  logic [SH-1:0] fill;

  always_comb begin
    fill = '0;
    dout = din;
    if (en && is_legal(op)) begin
      if (is_right(op)) begin
        // SRA keeps the MSB at every level, so chaining levels sign-fills correctly.
        if (op == SHIFT_SRA)      fill = {SH{din[WIDTH-1]}};
        else if (op == SHIFT_ROR) fill = din[SH-1:0];
        dout = {fill, din[WIDTH-1:SH]};
      end else begin
        if (op == SHIFT_ROL) fill = din[WIDTH-1:WIDTH-SH];
        dout = {din[WIDTH-SH-1:0], fill};
      end
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined WIDTH-bit shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready, flush and tag sideband.
module shift_pipe
  import shift_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 2,
  parameter  int TAG_W  = 5,
  localparam int SHW    = shamt_width(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [TAG_W-1:0] out_tag_o
);

  logic             valid_reg [STAGES];
  logic [WIDTH-1:0] data_reg  [STAGES];
  logic [SHW-1:0]   shamt_reg [STAGES];
  logic [2:0]       op_reg    [STAGES];
  logic [TAG_W-1:0] tag_reg   [STAGES];

  logic [WIDTH-1:0] stage_in_data  [STAGES];
  logic [SHW-1:0]   stage_in_shamt [STAGES];
  logic [2:0]       stage_in_op    [STAGES];
  logic [TAG_W-1:0] stage_in_tag   [STAGES];
  logic [WIDTH-1:0] stage_out_data [STAGES];

  logic [WIDTH-1:0] level_in  [SHW];
  logic [WIDTH-1:0] level_out [SHW];

  logic enable;

  // A stalled output freezes the whole pipe; bubbles are not collapsed.
  assign enable     = !out_valid_o || out_ready_i;
  assign in_ready_o = enable;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage_src
      if (gi == 0) begin : g_head
        assign stage_in_data[gi]  = data_i;
        assign stage_in_shamt[gi] = shamt_i;
        assign stage_in_op[gi]    = op_i;
        assign stage_in_tag[gi]   = tag_i;
      end else begin : g_body
        assign stage_in_data[gi]  = data_reg[gi-1];
        assign stage_in_shamt[gi] = shamt_reg[gi-1];
        assign stage_in_op[gi]    = op_reg[gi-1];
        assign stage_in_tag[gi]   = tag_reg[gi-1];
      end
    end

    for (gi = 0; gi < SHW; gi++) begin : g_level
      localparam int S     = stage_of(gi, STAGES, SHW);
      localparam bit FIRST = (gi == 0) || (stage_of(gi - 1, STAGES, SHW) != S);
      localparam bit LAST  = (gi == SHW - 1) || (stage_of(gi + 1, STAGES, SHW) != S);

      if (FIRST) begin : g_from_stage
        assign level_in[gi] = stage_in_data[S];
      end else begin : g_from_level
        assign level_in[gi] = level_out[gi-1];
      end

      shift_level #(.WIDTH(WIDTH), .K(gi)) u_level (
        .op   (stage_in_op[S]),
        .en   (stage_in_shamt[S][gi]),
        .din  (level_in[gi]),
        .dout (level_out[gi])
      );

      if (LAST) begin : g_stage_end
        assign stage_out_data[S] = level_out[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_reg[s] <= 1'b0;
        data_reg[s]  <= '0;
        shamt_reg[s] <= '0;
        op_reg[s]    <= '0;
        tag_reg[s]   <= '0;
      end
    end else begin
      if (enable) begin
        valid_reg[0] <= in_valid_i;
        for (int s = 1; s < STAGES; s++) valid_reg[s] <= valid_reg[s-1];
        for (int s = 0; s < STAGES; s++) begin
          data_reg[s]  <= stage_out_data[s];
          shamt_reg[s] <= stage_in_shamt[s];
          op_reg[s]    <= stage_in_op[s];
          tag_reg[s]   <= stage_in_tag[s];
        end
      end
      // Flush wins over enable, dropping the incoming operation too.
      if (flush_i) begin
        for (int s = 0; s < STAGES; s++) valid_reg[s] <= 1'b0;
      end
    end
  end

  assign out_valid_o = valid_reg[STAGES-1];
  assign out_data_o  = data_reg[STAGES-1];
  assign out_tag_o   = tag_reg[STAGES-1];

endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe (WIDTH=32, STAGES=2).
module tb_shift_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [2:0]  op_i;
  logic [31:0] data_i, out_data_o;
  logic [4:0]  shamt_i, tag_i, out_tag_o;

  int vectors = 0;
  int miscompares = 0;

  shift_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .data_i(data_i), .shamt_i(shamt_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_tag_o(out_tag_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] d,
                       input logic [4:0] sh, input logic [4:0] tg);
    in_valid_i = v; op_i = op; data_i = d; shamt_i = sh; tag_i = tg;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 5'd0, 5'd0);
    tick(); tick();
    rst_i = 1'b0;
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid_o); end
    vectors++; if (out_data_o !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", out_data_o); end
    vectors++; if (out_tag_o !== 5'd0) begin miscompares++; $display("FAIL reset_tag got %0d want 0", out_tag_o); end
    vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", in_ready_o); end
  endtask

  task automatic test_sra();
    drive(1'b1, 3'd2, 32'h8000_0000, 5'd31, 5'd1);
    tick();
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL sra_latency1 got %b want 0", out_valid_o); end
    drive(1'b1, 3'd2, 32'h7000_0000, 5'd4, 5'd2);
    tick();
    $display("sra op1: valid=%b data=%h tag=%0d", out_valid_o, out_data_o, out_tag_o);
    vectors++; if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL sra_latency2 got %b want 1", out_valid_o); end
    vectors++; if (out_data_o !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL sra_sign got %h want ffffffff", out_data_o); end
    vectors++; if (out_tag_o !== 5'd1) begin miscompares++; $display("FAIL sra_tag1 got %0d want 1", out_tag_o); end
    drive(1'b0, 3'd0, 32'h0, 5'd0, 5'd0);
    tick();
    $display("sra op2: valid=%b data=%h tag=%0d", out_valid_o, out_data_o, out_tag_o);
    vectors++; if (out_data_o !== 32'h0700_0000) begin miscompares++; $display("FAIL sra_pos got %h want 07000000", out_data_o); end
    vectors++; if (out_tag_o !== 5'd2) begin miscompares++; $display("FAIL sra_tag2 got %0d want 2", out_tag_o); end
    tick();
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL sra_drain got %b want 0", out_valid_o); end
  endtask

  task automatic test_all_ops();
    logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    logic [31:0] exp [6] = '{32'h0000_0002, 32'h4000_0000, 32'hC000_0000,
                             32'h0000_0003, 32'hC000_0000, 32'h8000_0001};
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive(1'b1, ops[i], 32'h8000_0001, 5'd1, 5'(i + 1));
      else       drive(1'b0, 3'd0, 32'h0, 5'd0, 5'd0);
      tick();
      if (i >= 1) begin
        $display("all_ops op=%0d: valid=%b data=%h tag=%0d", ops[i-1], out_valid_o, out_data_o, out_tag_o);
        vectors++; if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL ops_valid[%0d] got %b want 1", i-1, out_valid_o); end
        vectors++; if (out_data_o !== exp[i-1]) begin miscompares++; $display("FAIL ops_data[%0d] got %h want %h", i-1, out_data_o, exp[i-1]); end
        vectors++; if (out_tag_o !== 5'(i)) begin miscompares++; $display("FAIL ops_tag[%0d] got %0d want %0d", i-1, out_tag_o, i); end
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [8] = '{32'h01, 32'h02, 32'h04, 32'h08, 32'h10, 32'h20, 32'h40, 32'h80};
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        drive(1'b1, 3'd0, 32'h1, 5'(i), 5'(i + 10));
        vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready_o); end
      end else drive(1'b0, 3'd0, 32'h0, 5'd0, 5'd0);
      tick();
      if (i >= 1) begin
        $display("b2b %0d: valid=%b data=%h tag=%0d", i-1, out_valid_o, out_data_o, out_tag_o);
        vectors++; if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d] got %b want 1", i-1, out_valid_o); end
        vectors++; if (out_data_o !== exp[i-1]) begin miscompares++; $display("FAIL b2b_data[%0d] got %h want %h", i-1, out_data_o, exp[i-1]); end
        vectors++; if (out_tag_o !== 5'(i + 9)) begin miscompares++; $display("FAIL b2b_tag[%0d] got %0d want %0d", i-1, out_tag_o, i+9); end
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready_i = 1'b0;
    drive(1'b1, 3'd0, 32'h3, 5'd2, 5'd7);      // SLL -> 0xC
    tick();
    drive(1'b1, 3'd1, 32'h100, 5'd8, 5'd8);    // SRL -> 0x1
    tick();
    drive(1'b1, 3'd4, 32'h1, 5'd1, 5'd9);      // ROR -> 0x8000_0000, held until accepted
    for (int c = 0; c < 3; c++) begin
      tick();
      $display("stall %0d: ready=%b valid=%b data=%h tag=%0d", c, in_ready_o, out_valid_o, out_data_o, out_tag_o);
      vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d] got %b want 0", c, in_ready_o); end
      vectors++; if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d] got %b want 1", c, out_valid_o); end
      vectors++; if (out_data_o !== 32'hC) begin miscompares++; $display("FAIL bp_data[%0d] got %h want 0000000c", c, out_data_o); end
      vectors++; if (out_tag_o !== 5'd7) begin miscompares++; $display("FAIL bp_tag[%0d] got %0d want 7", c, out_tag_o); end
    end
    out_ready_i = 1'b1;
    #1;
    vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL bp_release got %b want 1", in_ready_o); end
    tick();
    drive(1'b0, 3'd0, 32'h0, 5'd0, 5'd0);
    $display("release B: valid=%b data=%h tag=%0d", out_valid_o, out_data_o, out_tag_o);
    vectors++; if (out_data_o !== 32'h1 || out_tag_o !== 5'd8 || out_valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_second got %h/%0d want 00000001/8", out_data_o, out_tag_o); end
    tick();
    $display("release C: valid=%b data=%h tag=%0d", out_valid_o, out_data_o, out_tag_o);
    vectors++; if (out_data_o !== 32'h8000_0000 || out_tag_o !== 5'd9 || out_valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_third got %h/%0d want 80000000/9", out_data_o, out_tag_o); end
    tick();
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_dup got %b want 0", out_valid_o); end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    drive(1'b1, 3'd0, 32'h5, 5'd1, 5'd20);
    tick();
    drive(1'b1, 3'd0, 32'h6, 5'd1, 5'd21);
    tick();
    drive(1'b1, 3'd0, 32'h7, 5'd1, 5'd22);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; out_ready_i = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 5'd0, 5'd0);
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_clear got %b want 0", out_valid_o); end
    tick();
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_drop got %b want 0", out_valid_o); end
    drive(1'b1, 3'd1, 32'hF0, 5'd4, 5'd3);
    tick();
    drive(1'b0, 3'd0, 32'h0, 5'd0, 5'd0);
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_lat1 got %b want 0", out_valid_o); end
    tick();
    $display("post-flush: valid=%b data=%h tag=%0d", out_valid_o, out_data_o, out_tag_o);
    vectors++; if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL flush_next_valid got %b want 1", out_valid_o); end
    vectors++; if (out_data_o !== 32'h0F) begin miscompares++; $display("FAIL flush_next_data got %h want 0000000f", out_data_o); end
    vectors++; if (out_tag_o !== 5'd3) begin miscompares++; $display("FAIL flush_next_tag got %0d want 3", out_tag_o); end
    tick();
  endtask

  task automatic test_reset_midstream();
    out_ready_i = 1'b1;
    drive(1'b1, 3'd3, 32'h1, 5'd3, 5'd11);
    tick();
    drive(1'b1, 3'd3, 32'h2, 5'd3, 5'd12);
    tick();
    rst_i = 1'b1;
    drive(1'b1, 3'd3, 32'h4, 5'd3, 5'd13);
    tick();
    $display("mid-reset: valid=%b data=%h tag=%0d ready=%b", out_valid_o, out_data_o, out_tag_o, in_ready_o);
    vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL mrst_valid got %b want 0", out_valid_o); end
    vectors++; if (out_data_o !== 32'h0) begin miscompares++; $display("FAIL mrst_data got %h want 0", out_data_o); end
    vectors++; if (out_tag_o !== 5'd0) begin miscompares++; $display("FAIL mrst_tag got %0d want 0", out_tag_o); end
    vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL mrst_ready got %b want 1", in_ready_o); end
    drive(1'b1, 3'd3, 32'h8, 5'd3, 5'd14);
    tick();
    rst_i = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 5'd0, 5'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL mrst_ghost[%0d] got %b want 0", c, out_valid_o); end
    end
  endtask

  initial begin
    test_reset();
    test_sra();
    test_all_ops();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
